// File: rtl/fifo_multicanal_if.sv
// Handshake/data bundle for the multi-channel FIFO bank: shared write and
// read ports with channel selects, threshold levels and per-channel status.
interface fifo_multicanal_if #(
    parameter int DATA_WIDTH = 4,
    parameter int BUF_WIDTH  = 3,
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 1
);
    logic [DATA_WIDTH-1:0]            buf_in;
    logic                             wr_en;
    logic [CH_W-1:0]                  wr_ch;
    logic                             rd_en;
    logic [CH_W-1:0]                  rd_ch;
    logic [BUF_WIDTH:0]               uH;
    logic [BUF_WIDTH:0]               uL;
    logic                             err_clr;
    logic [DATA_WIDTH-1:0]            buf_out;
    logic                             valid_out;
    logic [NUM_CH-1:0]                buf_full;
    logic [NUM_CH-1:0]                buf_empty;
    logic [NUM_CH-1:0]                almost_full;
    logic [NUM_CH-1:0]                almost_empty;
    logic [NUM_CH*(BUF_WIDTH+1)-1:0]  fifo_counter;
    logic [NUM_CH-1:0]                overflow_err;
    logic [NUM_CH-1:0]                underflow_err;

    modport master (
        output buf_in, wr_en, wr_ch, rd_en, rd_ch, uH, uL, err_clr,
        input  buf_out, valid_out, buf_full, buf_empty, almost_full,
               almost_empty, fifo_counter, overflow_err, underflow_err
    );

    modport slave (
        input  buf_in, wr_en, wr_ch, rd_en, rd_ch, uH, uL, err_clr,
        output buf_out, valid_out, buf_full, buf_empty, almost_full,
               almost_empty, fifo_counter, overflow_err, underflow_err
    );
endinterface

// File: rtl/fifo_multicanal.sv
// Multi-channel FIFO bank: NUM_CH independent circular buffers sharing one
// write port and one registered read port. Status flags are combinational
// from each channel's occupancy; overflow/underflow errors are sticky.
module fifo_multicanal #(
    parameter int DATA_WIDTH = 4,
    parameter int BUF_WIDTH  = 3,
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 1
) (
    input  logic               clk,
    input  logic               rst,
    fifo_multicanal_if.slave   bus
);
    localparam int DEPTH = 1 << BUF_WIDTH;
    localparam int CW    = BUF_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    // one extra bit so cnt+uH cannot wrap when uH is large
    localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r  [NUM_CH][DEPTH];
    logic [BUF_WIDTH-1:0]  wptr_r [NUM_CH];
    logic [BUF_WIDTH-1:0]  rptr_r [NUM_CH];
    logic [CW-1:0]         cnt_r  [NUM_CH];

    logic [NUM_CH-1:0]     wr_hit_s, rd_hit_s, wr_ok_s, rd_ok_s, ovf_s, unf_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  rd_any_s;

    logic [DATA_WIDTH-1:0] buf_out_r;
    logic                  valid_out_r;
    logic [NUM_CH-1:0]     ovf_err_r, unf_err_r;

    logic [NUM_CH-1:0]     full_s, empty_s, afull_s, aempty_s;
    logic [NUM_CH*CW-1:0]  counter_s;

    // Per-channel accept decisions; selects >= NUM_CH never match a channel
    always_comb begin
        wr_hit_s = '0;
        rd_hit_s = '0;
        wr_ok_s  = '0;
        rd_ok_s  = '0;
        ovf_s    = '0;
        unf_s    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit_s[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
            rd_hit_s[i] = bus.rd_en && (bus.rd_ch == CH_W'(i));
            // read uses pre-edge count, so no fall-through of this cycle's write
            rd_ok_s[i]  = rd_hit_s[i] && (cnt_r[i] != '0);
            unf_s[i]    = rd_hit_s[i] && (cnt_r[i] == '0);
            // a full channel still accepts a write if it is read in the same cycle
            wr_ok_s[i]  = wr_hit_s[i] && ((cnt_r[i] != DEPTH_C) || rd_ok_s[i]);
            ovf_s[i]    = wr_hit_s[i] && !wr_ok_s[i];
        end
    end

    // Read-data mux: at most one channel can have an accepted read
    always_comb begin
        rd_data_s = '0;
        rd_any_s  = |rd_ok_s;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ok_s[i]) begin
                rd_data_s = mem_r[i][rptr_r[i]];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Occupancy-derived status flags and packed counter
    always_comb begin
        full_s    = '0;
        empty_s   = '0;
        afull_s   = '0;
        aempty_s  = '0;
        counter_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            full_s[i]  = (cnt_r[i] == DEPTH_C);
            empty_s[i] = (cnt_r[i] == '0);
            afull_s[i] = (({1'b0, cnt_r[i]} + {1'b0, bus.uH}) >= DEPTH_X);
            aempty_s[i] = (cnt_r[i] <= bus.uL);
            counter_s[i*CW +: CW] = cnt_r[i];
        end
    end

    // Storage array; intentionally not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_ok_s[i]) begin
                mem_r[i][wptr_r[i]] <= bus.buf_in;
            end
        end
    end

    // Pointers and occupancy counters per channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wptr_r[i] <= '0;
                rptr_r[i] <= '0;
                cnt_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ok_s[i]) begin
                    wptr_r[i] <= wptr_r[i] + BUF_WIDTH'(1);
                end
                if (rd_ok_s[i]) begin
                    rptr_r[i] <= rptr_r[i] + BUF_WIDTH'(1);
                end
                case ({wr_ok_s[i], rd_ok_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CW'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - CW'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Registered read data, valid pulse and sticky errors (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_out_r   <= '0;
            valid_out_r <= 1'b0;
            ovf_err_r   <= '0;
            unf_err_r   <= '0;
        end else begin
            buf_out_r   <= rd_any_s ? rd_data_s : buf_out_r;
            valid_out_r <= rd_any_s;
            ovf_err_r   <= (bus.err_clr ? '0 : ovf_err_r) | ovf_s;
            unf_err_r   <= (bus.err_clr ? '0 : unf_err_r) | unf_s;
        end
    end

    assign bus.buf_out       = buf_out_r;
    assign bus.valid_out     = valid_out_r;
    assign bus.buf_full      = full_s;
    assign bus.buf_empty     = empty_s;
    assign bus.almost_full   = afull_s;
    assign bus.almost_empty  = aempty_s;
    assign bus.fifo_counter  = counter_s;
    assign bus.overflow_err  = ovf_err_r;
    assign bus.underflow_err = unf_err_r;
endmodule

// File: tb/tb_fifo_multicanal.sv
// Directed bench for fifo_multicanal: DATA_WIDTH=4, BUF_WIDTH=3, NUM_CH=2,
// uH=2, uL=3. Each scenario task drives stimulus and checks inline.
module tb_fifo_multicanal;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fifo_multicanal_if #(.DATA_WIDTH(4), .BUF_WIDTH(3), .NUM_CH(2), .CH_W(1)) bus ();

    fifo_multicanal #(.DATA_WIDTH(4), .BUF_WIDTH(3), .NUM_CH(2), .CH_W(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] cnt(input int ch);
        return bus.fifo_counter[ch*4 +: 4];
    endfunction

    // One clock with the given request; outputs are sampled 1 time unit later
    task automatic step(input logic we, input int wc, input logic [3:0] din,
                        input logic re, input int rc);
        bus.wr_en  = we;
        bus.wr_ch  = 1'(wc);
        bus.buf_in = din;
        bus.rd_en  = re;
        bus.rd_ch  = 1'(rc);
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.buf_empty !== 2'b11) begin errors++; $display("FAIL rst_empty got %b exp 11", bus.buf_empty); end
        checks++; if (bus.almost_empty !== 2'b11) begin errors++; $display("FAIL rst_aempty got %b exp 11", bus.almost_empty); end
        checks++; if (bus.fifo_counter !== 8'h00) begin errors++; $display("FAIL rst_counter got %h exp 00", bus.fifo_counter); end
        checks++; if (bus.buf_full !== 2'b00 || bus.almost_full !== 2'b00) begin errors++; $display("FAIL rst_full got %b/%b exp 00/00", bus.buf_full, bus.almost_full); end
        checks++; if (bus.buf_out !== 4'h0 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_out got %h/%b exp 0/0", bus.buf_out, bus.valid_out); end
        checks++; if (bus.overflow_err !== 2'b00 || bus.underflow_err !== 2'b00) begin errors++; $display("FAIL rst_err got %b/%b exp 00/00", bus.overflow_err, bus.underflow_err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int k = 1; k <= 3; k++) step(1'b1, 0, 4'(k), 1'b0, 0);
        checks++; if (cnt(0) !== 4'd3 || bus.almost_empty[0] !== 1'b1) begin errors++; $display("FAIL basic_cnt got %0d/%b exp 3/1", cnt(0), bus.almost_empty[0]); end
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 0, 4'h0, 1'b1, 0);
            checks++; if (bus.valid_out !== 1'b1 || bus.buf_out !== 4'(k)) begin errors++; $display("FAIL basic_pop got %h/%b exp %h/1", bus.buf_out, bus.valid_out, 4'(k)); end
        end
        checks++; if (cnt(0) !== 4'd0 || bus.buf_empty[0] !== 1'b1) begin errors++; $display("FAIL basic_drain got %0d exp 0", cnt(0)); end
        step(1'b0, 0, 4'h0, 1'b0, 0);
        checks++; if (bus.valid_out !== 1'b0 || bus.buf_out !== 4'h3) begin errors++; $display("FAIL basic_hold got %h/%b exp 3/0", bus.buf_out, bus.valid_out); end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1, 4'(k-1), 1'b0, 0);
            checks++; if (cnt(1) !== 4'(k)) begin errors++; $display("FAIL fill_cnt got %0d exp %0d", cnt(1), k); end
            checks++; if (bus.almost_full[1] !== (k >= 6)) begin errors++; $display("FAIL fill_afull k=%0d got %b", k, bus.almost_full[1]); end
            checks++; if (bus.buf_full[1] !== (k == 8)) begin errors++; $display("FAIL fill_full k=%0d got %b", k, bus.buf_full[1]); end
            checks++; if (bus.almost_empty[1] !== (k <= 3)) begin errors++; $display("FAIL fill_aempty k=%0d got %b", k, bus.almost_empty[1]); end
        end
        step(1'b1, 1, 4'hF, 1'b0, 0);
        checks++; if (cnt(1) !== 4'd8 || bus.overflow_err !== 2'b10) begin errors++; $display("FAIL fill_ovf got %0d/%b exp 8/10", cnt(1), bus.overflow_err); end
        checks++; if (bus.buf_empty[0] !== 1'b1 || bus.buf_full[0] !== 1'b0 || bus.almost_full[0] !== 1'b0 || cnt(0) !== 4'd0) begin errors++; $display("FAIL fill_ch0 got e%b f%b af%b c%0d", bus.buf_empty[0], bus.buf_full[0], bus.almost_full[0], cnt(0)); end
        bus.err_clr = 1'b1;
        step(1'b0, 0, 4'h0, 1'b0, 0);
        checks++; if (bus.overflow_err !== 2'b00) begin errors++; $display("FAIL fill_clr got %b exp 00", bus.overflow_err); end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 0, 4'h0, 1'b1, 1);
            checks++; if (bus.valid_out !== 1'b1 || bus.buf_out !== 4'(k)) begin errors++; $display("FAIL fill_drain got %h/%b exp %h/1", bus.buf_out, bus.valid_out, 4'(k)); end
        end
        checks++; if (cnt(1) !== 4'd0) begin errors++; $display("FAIL fill_end got %0d exp 0", cnt(1)); end
    endtask

    task automatic test_simul_full();
        for (int k = 0; k < 8; k++) step(1'b1, 0, 4'(k), 1'b0, 0);
        step(1'b1, 0, 4'h9, 1'b1, 0);
        checks++; if (bus.valid_out !== 1'b1 || bus.buf_out !== 4'h0) begin errors++; $display("FAIL simul_out got %h/%b exp 0/1", bus.buf_out, bus.valid_out); end
        checks++; if (cnt(0) !== 4'd8 || bus.overflow_err !== 2'b00) begin errors++; $display("FAIL simul_cnt got %0d/%b exp 8/00", cnt(0), bus.overflow_err); end
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 0, 4'h0, 1'b1, 0);
            checks++; if (bus.buf_out !== ((k == 8) ? 4'h9 : 4'(k))) begin errors++; $display("FAIL simul_drain got %h exp %h", bus.buf_out, (k == 8) ? 4'h9 : 4'(k)); end
        end
    endtask

    task automatic test_empty_write();
        step(1'b1, 0, 4'hA, 1'b1, 0);
        checks++; if (bus.valid_out !== 1'b0 || bus.buf_out !== 4'h9) begin errors++; $display("FAIL ew_out got %h/%b exp 9/0", bus.buf_out, bus.valid_out); end
        checks++; if (bus.underflow_err !== 2'b01 || cnt(0) !== 4'd1) begin errors++; $display("FAIL ew_state got %b/%0d exp 01/1", bus.underflow_err, cnt(0)); end
        step(1'b0, 0, 4'h0, 1'b1, 0);
        checks++; if (bus.valid_out !== 1'b1 || bus.buf_out !== 4'hA) begin errors++; $display("FAIL ew_pop got %h/%b exp A/1", bus.buf_out, bus.valid_out); end
        bus.err_clr = 1'b1;
        step(1'b0, 0, 4'h0, 1'b0, 0);
        checks++; if (bus.underflow_err !== 2'b00) begin errors++; $display("FAIL ew_clr got %b exp 00", bus.underflow_err); end
    endtask

    task automatic test_wrap();
        logic [3:0] q0[$];
        logic [3:0] q1[$];
        logic [3:0] exp_v;
        logic       re;
        int         wc;
        for (int i = 0; i < 20; i++) begin
            wc    = i % 2;
            re    = (wc == 0) ? (q1.size() != 0) : (q0.size() != 0);
            exp_v = 4'h0;
            if (re) exp_v = (wc == 0) ? q1.pop_front() : q0.pop_front();
            if (wc == 0) q0.push_back(4'(i + 3)); else q1.push_back(4'(i + 3));
            step(1'b1, wc, 4'(i + 3), re, 1 - wc);
            checks++; if (bus.valid_out !== re) begin errors++; $display("FAIL wrap_valid i=%0d got %b exp %b", i, bus.valid_out, re); end
            if (re) begin
                checks++; if (bus.buf_out !== exp_v) begin errors++; $display("FAIL wrap_data i=%0d got %h exp %h", i, bus.buf_out, exp_v); end
            end
            checks++; if (cnt(0) !== 4'(q0.size()) || cnt(1) !== 4'(q1.size())) begin errors++; $display("FAIL wrap_cnt i=%0d got %0d/%0d exp %0d/%0d", i, cnt(0), cnt(1), q0.size(), q1.size()); end
        end
        while (q1.size() != 0) begin
            exp_v = q1.pop_front();
            step(1'b0, 0, 4'h0, 1'b1, 1);
            checks++; if (bus.buf_out !== exp_v) begin errors++; $display("FAIL wrap_drain got %h exp %h", bus.buf_out, exp_v); end
        end
        while (q0.size() != 0) begin
            exp_v = q0.pop_front();
            step(1'b0, 0, 4'h0, 1'b1, 0);
            checks++; if (bus.buf_out !== exp_v) begin errors++; $display("FAIL wrap_drain0 got %h exp %h", bus.buf_out, exp_v); end
        end
        // sticky error: clear coincident with a new overflow keeps the bit
        for (int k = 0; k < 8; k++) step(1'b1, 1, 4'(k), 1'b0, 0);
        bus.err_clr = 1'b1;
        step(1'b1, 1, 4'hF, 1'b0, 0);
        checks++; if (bus.overflow_err !== 2'b10) begin errors++; $display("FAIL sticky_set got %b exp 10", bus.overflow_err); end
        bus.err_clr = 1'b1;
        step(1'b0, 0, 4'h0, 1'b0, 0);
        checks++; if (bus.overflow_err !== 2'b00) begin errors++; $display("FAIL sticky_clr got %b exp 00", bus.overflow_err); end
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 5; k++) step(1'b1, 0, 4'(k), 1'b0, 0);
        checks++; if (cnt(0) !== 4'd5) begin errors++; $display("FAIL mid_pre got %0d exp 5", cnt(0)); end
        rst = 1'b1;
        #1;
        checks++; if (bus.fifo_counter !== 8'h00 || bus.buf_empty !== 2'b11 || bus.buf_full !== 2'b00) begin errors++; $display("FAIL mid_rst got %h/%b/%b exp 00/11/00", bus.fifo_counter, bus.buf_empty, bus.buf_full); end
        checks++; if (bus.buf_out !== 4'h0 || bus.almost_empty !== 2'b11) begin errors++; $display("FAIL mid_out got %h/%b exp 0/11", bus.buf_out, bus.almost_empty); end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 0, 4'h0, 1'b1, 0);
        checks++; if (bus.valid_out !== 1'b0 || bus.underflow_err !== 2'b01 || bus.buf_out !== 4'h0) begin errors++; $display("FAIL mid_pop got v%b u%b d%h exp 0/01/0", bus.valid_out, bus.underflow_err, bus.buf_out); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        bus.buf_in  = 4'h0;
        bus.wr_en   = 1'b0;
        bus.wr_ch   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.rd_ch   = 1'b0;
        bus.uH      = 4'd2;
        bus.uL      = 4'd3;
        bus.err_clr = 1'b0;
        rst         = 1'b1;
        test_reset();
        test_basic();
        test_fill();
        test_simul_full();
        test_empty_write();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
